ccp_evict_addr_queue: RTL
=========================

Name: ccp_evict_addr_queue

Overview:
Successor to the single-cycle CCP evict-address composer.
- Rebuilds full line addresses for victim lines from set index, tag bank and victim tag, with a parametrised bank-field position.
- Buffers dirty evictions in a small FIFO and issues them to the writeback path over a valid/ready handshake.
- Provides a line-address hazard lookup against all pending evictions.
- Sits between the CCP tag pipeline's victim select and the writeback/SMI request builder.

Parameters:
- ADDRESS_W, 40: full address width.
- CACHE_LINE_OFFSET_W, 6: line offset bits. Issued addresses have this field zeroed.
- N_SETS, 1024: total sets across all banks.
- N_TAG_BANKS, 2: tag banks; power of 2, >=1.
- BNK_BIT_POS, CACHE_LINE_OFFSET_W+SET_PER_BANK_W: LSB of the bank field. Legal range CACHE_LINE_OFFSET_W..CACHE_LINE_OFFSET_W+SET_PER_BANK_W.
- QUEUE_DEPTH, 4: FIFO entries; power of 2, >=2.
- DROP_CLEAN, 1: if 1, clean evictions are accepted, counted and not enqueued. If 0, all evictions are enqueued.
- Derived:
  - SET_PER_BANK = N_SETS/N_TAG_BANKS
  - SET_PER_BANK_W = clog2(SET_PER_BANK)
  - BNK_W = clog2(N_TAG_BANKS)
  - TAG_W = ADDRESS_W-CACHE_LINE_OFFSET_W-SET_PER_BANK_W-BNK_W
  - CNT_W = clog2(QUEUE_DEPTH)+1

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- evict_valid  in  1  victim presented.
- evict_ready  out  1  queue can accept.
- evict_set  in  SET_PER_BANK_W  set index within bank.
- evict_bank  in  max(BNK_W,1)  tag bank; ignored when BNK_W=0.
- evict_tag  in  TAG_W  victim tag.
- evict_dirty  in  1  victim dirty.
- wb_valid  out  1  head entry valid.
- wb_ready  in  1  writeback consumer accepts.
- wb_addr  out  ADDRESS_W  head line address.
- wb_dirty  out  1  head dirty flag.
- lkup_valid  in  1  hazard lookup request.
- lkup_addr  in  ADDRESS_W  lookup address; offset bits ignored.
- lkup_hit  out  1  line matches a pending eviction.
- occupancy  out  CNT_W  entries held.
- drop_cnt  out  16  clean evictions dropped; saturating.

Behaviour:
- Reset is asynchronous on reset_n low. Queue empties and pointers clear; wb_valid=0, occupancy=0, drop_cnt=0. lkup_hit is 0 because the queue is empty.
  - Reset mid-transfer discards all entries. No wb handshake completes in the reset cycle.
- Address composition is combinational on the evict_* inputs. With L = BNK_BIT_POS-CACHE_LINE_OFFSET_W:
  - addr[OFF-1:0] = 0
  - set[L-1:0] goes at bit OFF upward
  - bank goes at BNK_BIT_POS
  - set[SET_W-1:L] goes above the bank field
  - tag fills the remaining MSBs
  - L=0 puts the bank directly above the offset. L=SET_PER_BANK_W puts the bank directly below the tag. BNK_W=0 means no bank field.
- Accept condition: evict_valid && evict_ready.
  - evict_ready = (occupancy < QUEUE_DEPTH). It is registered-state based, with no combinational path from wb_ready.
- Enqueue happens when accepted and (evict_dirty || !DROP_CLEAN). The composed address and dirty flag are written at the tail.
  - The entry appears on wb_valid no earlier than the next cycle; there is no bypass.
- Drop happens when accepted, DROP_CLEAN=1 and !evict_dirty. drop_cnt increments and saturates at 0xFFFF.
  - A drop still requires evict_ready=1.
- Dequeue happens when wb_valid && wb_ready; the head advances.
  - wb_addr/wb_dirty must stay stable while wb_valid=1 and wb_ready=0.
- Simultaneous enqueue and dequeue leaves occupancy unchanged; both pointers advance.
- When full, evict_ready=0. A pop in that cycle raises evict_ready in the next cycle, not the same one.
- Pointers wrap modulo QUEUE_DEPTH. occupancy is always 0..QUEUE_DEPTH.
- lkup_hit is combinational: lkup_valid && (a line-address match against any valid entry, including the head being popped this cycle, OR a match against the composed address of an evict accepted this cycle and being enqueued).
  - A dropped clean evict never hits.
- Assertions:
  - No enqueue when full.
  - No wb_valid when occupancy=0.
  - Parameter legality of BNK_BIT_POS, QUEUE_DEPTH and N_TAG_BANKS.

Decomposition:
- Shared package ccp_evict_pkg holds:
  - the derived-width functions (SET_PER_BANK_W, BNK_W, TAG_W);
  - the typedef evict_entry_t {addr, dirty};
  - the function compose_evict_addr(set, bank, tag), parametrised by BNK_BIT_POS.
- One sub-module, ccp_evict_fifo: a generic depth/width valid-ready FIFO exposing occupancy and an entry-valid vector plus the entry array for the CAM lookup.
- Address composition and the hazard compare stay in the top.

Test Plan:
Defaults (SET_W=9, BNK_W=1, TAG_W=24) unless stated.
1. Dirty evict set=0x1A5, bank=1, tag=0xABCDEF -> next cycle wb_valid=1, wb_addr=0xABCDEFE940, wb_dirty=1; pops with wb_ready=1 and occupancy returns to 0.
2. BNK_BIT_POS=6, same inputs -> wb_addr=0xABCDEFD2C0.
3. Push 4 dirty evicts with wb_ready=0 -> occupancy=4, evict_ready=0; a fifth valid is stalled; one pop -> evict_ready=1 next cycle; FIFO order is preserved.
4. DROP_CLEAN=1, clean evict -> no wb_valid, drop_cnt=1. 0x10000 clean evicts -> drop_cnt holds at 0xFFFF.
5. Hazard checks, with entry 0xABCDEFE940 queued:
   - lkup_addr=0xABCDEFE97F -> lkup_hit=1.
   - lkup_addr=0xABCDEFA940 -> lkup_hit=0.
   - Same-cycle accepted dirty evict to the lookup line -> lkup_hit=1.
6. Simultaneous push and pop at occupancy=4 -> push refused. At occupancy=2 -> occupancy stays 2. Assert reset_n mid-stream -> wb_valid=0 and occupancy=0 immediately.

Source files
------------

// File: rtl/ccp_evict_pkg.sv
// Shared types and helper functions for the CCP evict-address queue.
// The package has no parameters, so address values travel as MAX_ADDRESS_W-bit
// vectors and each user slices out the width it needs.
package ccp_evict_pkg;

    localparam int MAX_ADDRESS_W = 64;

    typedef logic [MAX_ADDRESS_W-1:0] addr_max_t;

    // One pending eviction: full line address plus its dirty flag.
    typedef struct packed {
        addr_max_t addr;
        logic      dirty;
    } evict_entry_t;

    function automatic int calc_set_per_bank_w(input int n_sets, input int n_tag_banks);
        return $clog2(n_sets / n_tag_banks);
    endfunction

    function automatic int calc_bnk_w(input int n_tag_banks);
        return $clog2(n_tag_banks);
    endfunction

    function automatic int calc_tag_w(input int address_w, input int off_w,
                                      input int n_sets, input int n_tag_banks);
        return address_w - off_w - calc_set_per_bank_w(n_sets, n_tag_banks)
               - calc_bnk_w(n_tag_banks);
    endfunction

    // Rebuild a line address. The set index is split at L = bnk_bit_pos - off_w:
    // its low L bits sit just above the offset, the bank field sits at
    // bnk_bit_pos, the remaining set bits go above the bank, and the tag
    // fills the MSBs. A zero-width bank field masks the bank input away.
    function automatic addr_max_t compose_evict_addr(input addr_max_t set,
                                                     input addr_max_t bank,
                                                     input addr_max_t tag,
                                                     input int        off_w,
                                                     input int        set_w,
                                                     input int        bnk_w,
                                                     input int        bnk_bit_pos);
        addr_max_t lo_mask;
        addr_max_t bnk_mask;
        addr_max_t addr;
        int        l;
        l        = bnk_bit_pos - off_w;
        lo_mask  = (addr_max_t'(1) << l) - addr_max_t'(1);
        bnk_mask = (addr_max_t'(1) << bnk_w) - addr_max_t'(1);
        addr     = (set & lo_mask) << off_w;
        addr     = addr | ((bank & bnk_mask) << bnk_bit_pos);
        addr     = addr | ((set >> l) << (bnk_bit_pos + bnk_w));
        addr     = addr | (tag << (off_w + set_w + bnk_w));
        return addr;
    endfunction

endpackage

// File: rtl/ccp_evict_fifo.sv
// Generic valid/ready FIFO. Besides the usual head interface it exposes the
// raw entry array and a per-slot valid vector so the parent can run a CAM
// style compare across everything still pending.
module ccp_evict_fifo #(
    parameter int   DEPTH = 4,
    parameter int   WIDTH = 8,
    localparam int  PTR_W = $clog2(DEPTH),
    localparam int  CNT_W = PTR_W + 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push_valid,
    output logic                         push_ready,
    input  logic [WIDTH-1:0]             push_data,
    output logic                         pop_valid,
    input  logic                         pop_ready,
    output logic [WIDTH-1:0]             pop_data,
    output logic [CNT_W-1:0]             occupancy,
    output logic [DEPTH-1:0]             entry_valid,
    output logic [DEPTH-1:0][WIDTH-1:0]  entries
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W-1:0]            rd_ptr;
    logic [CNT_W-1:0]            count;
    logic                        push_fire;
    logic                        pop_fire;

    // Ready and valid come only from registered count, so there is no
    // combinational path from pop_ready to push_ready.
    assign push_ready = (count < CNT_W'(DEPTH));
    assign pop_valid  = (count != '0);
    assign push_fire  = push_valid && push_ready;
    assign pop_fire   = pop_valid && pop_ready;
    assign pop_data   = mem[rd_ptr];
    assign occupancy  = count;
    assign entries    = mem;

    // Pointer and count update; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value of its inputs regardless of block order.
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_fire)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_fire, pop_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage write at the tail.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; entry_valid and
        // count decide what is meaningful, so stale data is never observed.
        if (push_fire) mem[wr_ptr] <= push_data;
    end

    // A slot is live when its distance from the head is below the count.
    always_comb begin
        // NOTE: default assignment first so no path leaves the vector unassigned
        // and no latch is inferred.
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = ({1'b0, PTR_W'(i) - rd_ptr} < count);
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset_n)
        (count == CNT_W'(DEPTH)) |-> !push_fire);

    a_count_in_range: assert property (@(posedge clk) disable iff (!reset_n)
        count <= CNT_W'(DEPTH));

    a_depth_legal: assert property (@(posedge clk)
        (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0));

endmodule

// File: rtl/ccp_evict_addr_queue.sv
// CCP evict-address queue: composes victim line addresses, buffers dirty
// evictions for the writeback path, counts dropped clean victims and answers
// line-address hazard lookups against everything still pending.
module ccp_evict_addr_queue
    import ccp_evict_pkg::*;
#(
    parameter int   ADDRESS_W           = 40,
    parameter int   CACHE_LINE_OFFSET_W = 6,
    parameter int   N_SETS              = 1024,
    parameter int   N_TAG_BANKS         = 2,
    parameter int   BNK_BIT_POS         = CACHE_LINE_OFFSET_W + calc_set_per_bank_w(N_SETS, N_TAG_BANKS),
    parameter int   QUEUE_DEPTH         = 4,
    parameter bit   DROP_CLEAN          = 1'b1,
    localparam int  SET_PER_BANK_W      = calc_set_per_bank_w(N_SETS, N_TAG_BANKS),
    localparam int  BNK_W               = calc_bnk_w(N_TAG_BANKS),
    localparam int  BNK_PW              = (BNK_W > 0) ? BNK_W : 1,
    localparam int  TAG_W               = calc_tag_w(ADDRESS_W, CACHE_LINE_OFFSET_W, N_SETS, N_TAG_BANKS),
    localparam int  CNT_W               = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      evict_valid,
    output logic                      evict_ready,
    input  logic [SET_PER_BANK_W-1:0] evict_set,
    input  logic [BNK_PW-1:0]         evict_bank,
    input  logic [TAG_W-1:0]          evict_tag,
    input  logic                      evict_dirty,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [ADDRESS_W-1:0]      wb_addr,
    output logic                      wb_dirty,
    input  logic                      lkup_valid,
    input  logic [ADDRESS_W-1:0]      lkup_addr,
    output logic                      lkup_hit,
    output logic [CNT_W-1:0]          occupancy,
    output logic [15:0]               drop_cnt
);

    localparam int OFF     = CACHE_LINE_OFFSET_W;
    localparam int ENTRY_W = ADDRESS_W + 1;

    localparam bit PARAMS_OK =
        (BNK_BIT_POS >= OFF) && (BNK_BIT_POS <= OFF + SET_PER_BANK_W) &&
        (N_TAG_BANKS >= 1) && ((N_TAG_BANKS & (N_TAG_BANKS - 1)) == 0) &&
        (QUEUE_DEPTH >= 2) && ((QUEUE_DEPTH & (QUEUE_DEPTH - 1)) == 0) &&
        (OFF >= 1) && (TAG_W >= 1) && (ADDRESS_W <= MAX_ADDRESS_W);

    evict_entry_t                        in_entry;
    evict_entry_t                        head_entry;
    logic [ADDRESS_W-1:0]                composed_addr;
    logic [ENTRY_W-1:0]                  head_data;
    logic [QUEUE_DEPTH-1:0]              entry_valid;
    logic [QUEUE_DEPTH-1:0][ENTRY_W-1:0] fifo_entries;
    logic                                push_valid;
    logic                                accept;
    logic                                enq;
    logic                                drop;
    logic                                match_any;
    logic                                unused_bits;

    // Compose the victim line address from set, bank and tag.
    always_comb begin
        in_entry.addr  = compose_evict_addr(addr_max_t'(evict_set), addr_max_t'(evict_bank),
                                            addr_max_t'(evict_tag), OFF, SET_PER_BANK_W,
                                            BNK_W, BNK_BIT_POS);
        in_entry.dirty = evict_dirty;
    end

    assign composed_addr = in_entry.addr[ADDRESS_W-1:0];

    // Clean victims bypass the queue when DROP_CLEAN is set, but they still
    // need evict_ready so the upstream handshake stays uniform.
    assign push_valid = evict_valid && (evict_dirty || !DROP_CLEAN);
    assign accept     = evict_valid && evict_ready;
    assign enq        = push_valid && evict_ready;
    assign drop       = accept && DROP_CLEAN && !evict_dirty;

    ccp_evict_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_valid  (push_valid),
        .push_ready  (evict_ready),
        .push_data   ({composed_addr, in_entry.dirty}),
        .pop_valid   (wb_valid),
        .pop_ready   (wb_ready),
        .pop_data    (head_data),
        .occupancy   (occupancy),
        .entry_valid (entry_valid),
        .entries     (fifo_entries)
    );

    // Unpack the head entry for the writeback interface.
    always_comb begin
        head_entry.addr  = addr_max_t'(head_data[ENTRY_W-1:1]);
        head_entry.dirty = head_data[0];
    end

    assign wb_addr  = head_entry.addr[ADDRESS_W-1:0];
    assign wb_dirty = head_entry.dirty;

    // Saturating count of dropped clean evictions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // Line-granular hazard compare against every live entry (the head being
    // popped this cycle is still live) and against a victim being enqueued now.
    always_comb begin
        match_any = 1'b0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (entry_valid[i] &&
                (fifo_entries[i][ENTRY_W-1:OFF+1] == lkup_addr[ADDRESS_W-1:OFF])) begin
                match_any = 1'b1;
            end
        end
        if (enq && (composed_addr[ADDRESS_W-1:OFF] == lkup_addr[ADDRESS_W-1:OFF])) begin
            match_any = 1'b1;
        end
    end

    assign lkup_hit = lkup_valid && match_any;

    // Offset bits, dirty bits of the array and the upper bits of the wide
    // package type are intentionally not consumed.
    assign unused_bits = ^{in_entry, head_entry, lkup_addr, fifo_entries};

    a_no_wb_when_empty: assert property (@(posedge clk) disable iff (!reset_n)
        wb_valid |-> (occupancy != '0));

    a_no_enq_when_full: assert property (@(posedge clk) disable iff (!reset_n)
        (occupancy == CNT_W'(QUEUE_DEPTH)) |-> !enq);

    a_params_legal: assert property (@(posedge clk) PARAMS_OK);

endmodule
